// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and FSM state encoding for the multi-port integer register file.
package reg_file_mp_pkg;

  localparam int RF_DATA_W_DEF = 32;
  localparam int RF_NREGS_DEF  = 32;
  localparam int RF_NRD_DEF    = 2;
  localparam int RF_NWR_DEF    = 1;

  typedef enum logic {
    RF_READY = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: x0 test, clear-sweep masking and optional write bypass.
module reg_file_rd_port
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W_DEF,
  parameter int AW     = 5,
  parameter int NWR    = RF_NWR_DEF,
  parameter int BYPASS = 0
) (
  input  rf_state_e               state,
  input  logic [AW-1:0]           rnum,
  input  logic [DATA_W-1:0]       stored,
  input  logic [NWR-1:0]          wen,
  input  logic [NWR*AW-1:0]       wnum,
  input  logic [NWR*DATA_W-1:0]   wd,
  output logic [DATA_W-1:0]       rd
);

  always_comb begin
    rd = stored;
    if (BYPASS != 0) begin
      // ascending scan so the highest-index matching write port wins
      for (int j = 0; j < NWR; j++) begin
        if (wen[j] && (wnum[j*AW +: AW] == rnum)) begin
          rd = wd[j*DATA_W +: DATA_W];
        end
      end
    end
    if ((rnum == '0) || (state == RF_CLEAR)) begin
      rd = '0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with x0 hardwired to zero and a reset-triggered clear sweep.
//   state    | meaning
//   RF_CLEAR | sweeping x1..x(NREGS-1) to zero, one per cycle; writes ignored, reads return 0
//   RF_READY | normal operation
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int  DATA_W     = RF_DATA_W_DEF,
  parameter int  NREGS      = RF_NREGS_DEF,
  parameter int  NRD        = RF_NRD_DEF,
  parameter int  NWR        = RF_NWR_DEF,
  parameter int  BYPASS     = 0,
  parameter int  CLR_ON_RST = 1,
  localparam int AW         = $clog2(NREGS)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NRD*AW-1:0]       i_rnum,
  output logic [NRD*DATA_W-1:0]   o_rd,
  input  logic [NWR-1:0]          i_wen,
  input  logic [NWR*AW-1:0]       i_wnum,
  input  logic [NWR*DATA_W-1:0]   i_wd,
  output logic                    o_busy
);

  logic [DATA_W-1:0] mem [NREGS];
  rf_state_e         state, state_nxt;
  logic [AW-1:0]     clr_ptr, clr_ptr_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= (CLR_ON_RST != 0) ? RF_CLEAR : RF_READY;
      clr_ptr <= AW'(1);
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // pointer holds at the last register so it never wraps back to x0
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    if (state == RF_CLEAR) begin
      if (clr_ptr == AW'(NREGS - 1)) begin
        state_nxt = RF_READY;
      end else begin
        clr_ptr_nxt = clr_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    o_busy = (state == RF_CLEAR);
  end

  // later loop iterations override earlier ones: highest-index write port wins
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (state == RF_CLEAR) begin
        mem[clr_ptr] <= '0;
      end else begin
        for (int j = 0; j < NWR; j++) begin
          if (i_wen[j] && (i_wnum[j*AW +: AW] != '0)) begin
            mem[i_wnum[j*AW +: AW]] <= i_wd[j*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    reg_file_rd_port #(
      .DATA_W (DATA_W),
      .AW     (AW),
      .NWR    (NWR),
      .BYPASS (BYPASS)
    ) u_rd (
      .state  (state),
      .rnum   (i_rnum[k*AW +: AW]),
      .stored (mem[i_rnum[k*AW +: AW]]),
      .wen    (i_wen),
      .wnum   (i_wnum),
      .wd     (i_wd),
      .rd     (o_rd[k*DATA_W +: DATA_W])
    );
  end

endmodule
